rsa_modexp_ctrl: RTL and testbench

- Sequencer for the RSA modular-exponentiation datapath. Computes c = m^e mod n by left-to-right binary square-and-multiply.
- Drives an external shared modular multiplier through a req/ack handshake.
- Two scan modes:
  - fast mode: multiplies only on '1' exponent bits. Timing is data-dependent, which is the leaky reference behaviour.
  - constant-time mode: multiplies on every bit and discards the result on '0' bits.
- Exposes a cycle counter so the side-channel bench can measure both modes.

---
 rtl/rsa_modexp_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_rsa_modexp_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer for c = m^e mod n, driving a shared
// modular multiplier over a level req / pulse ack handshake, in fast or constant-time scan.
module rsa_modexp_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 ct_mode,
    input  logic [WIDTH-1:0]     m,
    input  logic [WIDTH-1:0]     e,
    input  logic [2*WIDTH-1:0]   n,
    output logic                 mul_req,
    output logic [2*WIDTH-1:0]   mul_a,
    output logic [2*WIDTH-1:0]   mul_b,
    output logic [2*WIDTH-1:0]   mul_n,
    input  logic                 mul_ack,
    input  logic [2*WIDTH-1:0]   mul_p,
    output logic [2*WIDTH-1:0]   c,
    output logic                 finish,
    output logic                 busy,
    output logic                 err,
    output logic [CNT_W-1:0]     cyc_cnt
);

    localparam int DW    = 2 * WIDTH;
    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BIT_W-1:0] BIT_TOP = BIT_W'(WIDTH - 1);
    localparam logic [DW-1:0]    ONE     = DW'(1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        INIT = 3'd1,
        SQ   = 3'd2,
        MUL  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t            state_q;
    logic [DW-1:0]     acc_q;
    logic [DW-1:0]     m_q;
    logic [WIDTH-1:0]  e_q;
    logic              ct_q;
    logic [BIT_W-1:0]  bit_q;
    logic              mul_req_q;
    logic [DW-1:0]     mul_a_q;
    logic [DW-1:0]     mul_b_q;
    logic [DW-1:0]     mul_n_q;
    logic [DW-1:0]     c_q;
    logic              finish_q;
    logic              busy_q;
    logic              err_q;
    logic [CNT_W-1:0]  cyc_cnt_q;

    logic              ebit;
    logic              last_bit;
    logic [DW-1:0]     mul_acc_d;
    logic [CNT_W-1:0]  cyc_cnt_d;

    always_comb begin
        ebit      = e_q[bit_q];
        last_bit  = (bit_q == '0);
        // In constant-time mode a multiply on a 0 bit still runs; its product is dropped here.
        mul_acc_d = ebit ? mul_p : acc_q;
        cyc_cnt_d = (&cyc_cnt_q) ? cyc_cnt_q : cyc_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            m_q       <= '0;
            e_q       <= '0;
            ct_q      <= 1'b0;
            bit_q     <= '0;
            mul_req_q <= 1'b0;
            mul_a_q   <= '0;
            mul_b_q   <= '0;
            mul_n_q   <= '0;
            c_q       <= '0;
            finish_q  <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            cyc_cnt_q <= '0;
        end else begin
            finish_q <= 1'b0;
            if (state_q != IDLE) begin
                cyc_cnt_q <= cyc_cnt_d;
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        m_q       <= {{WIDTH{1'b0}}, m};
                        e_q       <= e;
                        mul_n_q   <= n;
                        ct_q      <= ct_mode;
                        err_q     <= 1'b0;
                        cyc_cnt_q <= '0;
                        acc_q     <= ONE;
                        bit_q     <= BIT_TOP;
                        busy_q    <= 1'b1;
                        state_q   <= INIT;
                    end
                end

                INIT: begin
                    if (mul_n_q == '0 || mul_n_q == ONE) begin
                        err_q    <= (mul_n_q == '0);
                        acc_q    <= '0;
                        c_q      <= '0;
                        finish_q <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        mul_req_q <= 1'b1;
                        mul_a_q   <= acc_q;
                        mul_b_q   <= acc_q;
                        state_q   <= SQ;
                    end
                end

                SQ: begin
                    if (mul_ack) begin
                        acc_q <= mul_p;
                        if (ct_q || ebit) begin
                            mul_a_q <= mul_p;
                            mul_b_q <= m_q;
                            state_q <= MUL;
                        end else if (last_bit) begin
                            mul_req_q <= 1'b0;
                            c_q       <= mul_p;
                            finish_q  <= 1'b1;
                            state_q   <= DONE;
                        end else begin
                            bit_q   <= bit_q - BIT_W'(1);
                            mul_a_q <= mul_p;
                            mul_b_q <= mul_p;
                        end
                    end
                end

                MUL: begin
                    if (mul_ack) begin
                        acc_q <= mul_acc_d;
                        if (last_bit) begin
                            mul_req_q <= 1'b0;
                            c_q       <= mul_acc_d;
                            finish_q  <= 1'b1;
                            state_q   <= DONE;
                        end else begin
                            bit_q   <= bit_q - BIT_W'(1);
                            mul_a_q <= mul_acc_d;
                            mul_b_q <= mul_acc_d;
                            state_q <= SQ;
                        end
                    end
                end

                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    mul_req_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign mul_req = mul_req_q;
    assign mul_a   = mul_a_q;
    assign mul_b   = mul_b_q;
    assign mul_n   = mul_n_q;
    assign c       = c_q;
    assign finish  = finish_q;
    assign busy    = busy_q;
    assign err     = err_q;
    assign cyc_cnt = cyc_cnt_q;

endmodule

// File: tb/tb_rsa_modexp_ctrl.sv
// Bench for rsa_modexp_ctrl: behavioural modular multiplier with configurable ack latency,
// vector table plus scoreboard of expected results popped on each finish pulse.
module tb_rsa_modexp_ctrl;

    localparam int WIDTH = 8;
    localparam int CNT_W = 16;

    logic              clk;
    logic              rst;
    logic              start;
    logic              ct_mode;
    logic [7:0]        m;
    logic [7:0]        e;
    logic [15:0]       n;
    logic              mul_req;
    logic [15:0]       mul_a;
    logic [15:0]       mul_b;
    logic [15:0]       mul_n;
    logic              mul_ack;
    logic [15:0]       mul_p;
    logic [15:0]       c;
    logic              finish;
    logic              busy;
    logic              err;
    logic [CNT_W-1:0]  cyc_cnt;

    rsa_modexp_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .ct_mode (ct_mode),
        .m       (m),
        .e       (e),
        .n       (n),
        .mul_req (mul_req),
        .mul_a   (mul_a),
        .mul_b   (mul_b),
        .mul_n   (mul_n),
        .mul_ack (mul_ack),
        .mul_p   (mul_p),
        .c       (c),
        .finish  (finish),
        .busy    (busy),
        .err     (err),
        .cyc_cnt (cyc_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] c;
        logic        err;
        int          cyc;
    } exp_t;

    typedef struct {
        logic        ct;
        logic [7:0]  m;
        logic [7:0]  e;
        logic [15:0] n;
        int          d;
        logic [15:0] c;
        logic        err;
        int          cyc;
        int          txn;
    } vec_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    int   fixed_d    = 1;
    int   txn_cnt    = 0;
    int   stray_req  = 0;
    int   stray_done = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [15:0] modmul(input logic [15:0] a, input logic [15:0] b,
                                           input logic [15:0] nn);
        longint p;
        if (nn == 16'd0) return 16'd0;
        p = (longint'(a) * longint'(b)) % longint'(nn);
        return p[15:0];
    endfunction

    // Reference by plain repeated multiplication, deliberately not square-and-multiply.
    function automatic logic [15:0] ref_modexp(input logic [7:0] mm, input logic [7:0] ee,
                                               input logic [15:0] nn);
        longint r;
        if (nn <= 16'd1) return 16'd0;
        r = 1;
        for (int i = 0; i < int'(ee); i++) r = (r * longint'(mm)) % longint'(nn);
        return r[15:0];
    endfunction

    // Multiplier model: a transaction starts in any cycle with mul_req high after the
    // previous ack edge; ack is raised D cycles later for exactly one cycle.
    logic [15:0] cap_a, cap_b, cap_n;
    int          dl;
    bit          aborted;
    initial begin
        mul_ack = 1'b0;
        mul_p   = '0;
        forever begin
            @(posedge clk); #1;
            mul_ack = 1'b0;
            if (mul_req) begin
                cap_a   = mul_a;
                cap_b   = mul_b;
                cap_n   = mul_n;
                dl      = (fixed_d == 0) ? int'($urandom_range(1, 5)) : fixed_d;
                txn_cnt++;
                aborted = 1'b0;
                for (int k = 0; k < dl; k++) begin
                    @(posedge clk); #1;
                    if (!mul_req) begin
                        aborted = 1'b1;
                        break;
                    end
                end
                if (!aborted) begin
                    check("operands_stable", {mul_a, mul_b, mul_n}, {cap_a, cap_b, cap_n});
                    mul_ack = 1'b1;
                    mul_p   = modmul(cap_a, cap_b, cap_n);
                end
            end else if (stray_req != stray_done) begin
                mul_ack = 1'b1;
                mul_p   = 16'hBEEF;
                stray_done++;
            end
        end
    end

    // Scoreboard monitor: compare on finish, then check the settled IDLE state a cycle later.
    exp_t mon_it;
    bit   pend     = 1'b0;
    exp_t pend_it;
    initial begin
        forever begin
            @(negedge clk);
            if (pend) begin
                pend = 1'b0;
                check("busy_after_done", busy, 0);
                check("finish_one_cycle", finish, 0);
                check("c_held", c, pend_it.c);
                check("err_held", err, pend_it.err);
                if (pend_it.cyc >= 0) check("cyc_cnt", cyc_cnt, pend_it.cyc);
            end
            if (finish) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_finish: got finish=1 expected no finish");
                end else begin
                    mon_it = sb_q.pop_front();
                    check("c", c, mon_it.c);
                    check("err", err, mon_it.err);
                    check("busy_in_done", busy, 1);
                    pend_it = mon_it;
                    pend    = 1'b1;
                end
            end
        end
    end

    task automatic run_op(input logic ct, input logic [7:0] mm, input logic [7:0] ee,
                          input logic [15:0] nn, input int d, input logic [15:0] xc,
                          input logic xerr, input int xcyc, input int xtxn, input bit repulse);
        exp_t it;
        int   t;
        int   base;
        it.c    = xc;
        it.err  = xerr;
        it.cyc  = xcyc;
        fixed_d = d;
        base    = txn_cnt;
        @(posedge clk); #1;
        start   = 1'b1;
        ct_mode = ct;
        m       = mm;
        e       = ee;
        n       = nn;
        sb_q.push_back(it);
        @(posedge clk); #1;
        start   = 1'b0;
        ct_mode = ~ct;
        m       = 8'($urandom);
        e       = 8'($urandom);
        n       = 16'($urandom);
        if (repulse) begin
            repeat (4) @(posedge clk);
            #1;
            start = 1'b1;
            n     = 16'd0;
            @(posedge clk); #1;
            start = 1'b0;
        end
        t = 0;
        while (sb_q.size() != 0 && t < 4000) begin
            @(negedge clk);
            t++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL op_timeout: got no finish in %0d cycles expected finish", t);
            sb_q.delete();
        end
        repeat (2) @(negedge clk);
        if (xtxn >= 0) check("txn_count", txn_cnt - base, xtxn);
    endtask

    vec_t        tab [9];
    int          t;
    logic [15:0] rn;
    logic [7:0]  rm;
    logic [7:0]  re;

    initial begin
        #3000000;
        $display("FAIL watchdog: got no end of test expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // ct, m, e, n, D, c, err, cyc, transactions  (5 has order 10 mod 33)
        tab[0] = '{1'b0, 8'd5, 8'd3,   16'd33, 1, 16'd26, 1'b0, 22, 10};
        tab[1] = '{1'b1, 8'd5, 8'd3,   16'd33, 1, 16'd26, 1'b0, 34, 16};
        tab[2] = '{1'b1, 8'd5, 8'h80,  16'd33, 1, 16'd4,  1'b0, 34, 16};
        tab[3] = '{1'b1, 8'd5, 8'hFF,  16'd33, 1, 16'd23, 1'b0, 34, 16};
        tab[4] = '{1'b0, 8'd7, 8'd0,   16'd33, 1, 16'd1,  1'b0, 18, 8};
        tab[5] = '{1'b0, 8'd7, 8'd0,   16'd1,  1, 16'd0,  1'b0, 2,  0};
        tab[6] = '{1'b0, 8'd7, 8'd0,   16'd0,  1, 16'd0,  1'b1, 2,  0};
        tab[7] = '{1'b0, 8'd5, 8'h80,  16'd33, 2, 16'd4,  1'b0, 29, 9};
        tab[8] = '{1'b0, 8'd5, 8'd3,   16'd33, 3, 16'd26, 1'b0, 42, 10};

        rst = 1'b1; start = 1'b0; ct_mode = 1'b0; m = '0; e = '0; n = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mul_req", mul_req, 0);
        check("rst_finish", finish, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_c", c, 0);
        check("rst_cyc_cnt", cyc_cnt, 0);
        check("rst_mul_abn", {mul_a, mul_b, mul_n}, 0);
        rst = 1'b0;

        foreach (tab[i]) begin
            run_op(tab[i].ct, tab[i].m, tab[i].e, tab[i].n, tab[i].d,
                   tab[i].c, tab[i].err, tab[i].cyc, tab[i].txn, 1'b0);
        end

        // Stray acks while idle must not disturb anything.
        stray_req = stray_req + 2;
        repeat (6) @(negedge clk);
        check("stray_busy", busy, 0);
        check("stray_c", c, tab[8].c);
        check("stray_cyc_cnt", cyc_cnt, tab[8].cyc);
        check("stray_consumed", stray_done, stray_req);

        // Random per-transaction latency with start re-pulsed mid-operation.
        run_op(1'b0, 8'd9, 8'hB7, 16'd1000, 0, ref_modexp(8'd9, 8'hB7, 16'd1000),
               1'b0, -1, WIDTH + $countones(8'hB7), 1'b1);
        run_op(1'b1, 8'd200, 8'h5A, 16'd40001, 0, ref_modexp(8'd200, 8'h5A, 16'd40001),
               1'b0, -1, 2 * WIDTH, 1'b1);

        // Asynchronous reset while a MUL transaction is outstanding.
        fixed_d = 3;
        @(posedge clk); #1;
        start = 1'b1; ct_mode = 1'b1; m = 8'd5; e = 8'h80; n = 16'd33;
        @(posedge clk); #1;
        start = 1'b0;
        t = 0;
        while (!(mul_req && mul_b == 16'd5) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("reached_mul", (t < 200), 1);
        rst = 1'b1;
        #1;
        check("arst_mul_req", mul_req, 0);
        check("arst_busy", busy, 0);
        check("arst_c", c, 0);
        check("arst_cyc_cnt", cyc_cnt, 0);
        check("arst_err", err, 0);
        check("arst_mul_abn", {mul_a, mul_b, mul_n}, 0);
        repeat (3) begin
            @(negedge clk);
            check("arst_no_finish", finish, 0);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_idle", busy, 0);
        run_op(1'b0, 8'd5, 8'd3, 16'd33, 1, 16'd26, 1'b0, 22, 10, 1'b0);

        // Random operands in both modes; constant-time cycle count fixed at D=2.
        for (int i = 0; i < 200; i++) begin
            rn = 16'($urandom_range(2, 65535));
            rm = 8'($urandom_range(0, (rn > 16'd256) ? 255 : int'(rn) - 1));
            re = 8'($urandom);
            run_op(1'b0, rm, re, rn, 0, ref_modexp(rm, re, rn), 1'b0, -1,
                   WIDTH + $countones(re), (i % 25) == 0);
            run_op(1'b1, rm, re, rn, 2, ref_modexp(rm, re, rn), 1'b0,
                   2 + 2 * WIDTH * (2 + 1), 2 * WIDTH, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
